// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    ModeRgb565  = 2'b00,
    ModeYuvGrey = 2'b01,
    ModeTest    = 2'b10,
    ModeRsvd    = 2'b11
  } mode_e;

  typedef enum logic {
    PhFirst  = 1'b0,
    PhSecond = 1'b1
  } phase_e;

  localparam int unsigned RGB444_W = 12;

endpackage

// File: rtl/cam_capture_param_if.sv
// Camera input bus plus frame-buffer write port of the capture block.
interface cam_capture_param_if #(
  parameter int unsigned ADDR_W = 17
) ();
  import cam_pkg::*;

  logic                vsync;
  logic                href;
  logic [7:0]          d;
  logic                enable;
  logic [1:0]          mode;
  logic [ADDR_W-1:0]   addr;
  logic [RGB444_W-1:0] dout;
  logic                we;
  logic                frame_done;
  logic                line_err;
  logic [15:0]         frame_cnt;

  modport master (
    output vsync, href, d, enable, mode,
    input  addr, dout, we, frame_done, line_err, frame_cnt
  );

  modport slave (
    input  vsync, href, d, enable, mode,
    output addr, dout, we, frame_done, line_err, frame_cnt
  );

endinterface

// File: rtl/cam_pix_convert.sv
// Combinational pixel-format conversion to RGB444.
module cam_pix_convert
  import cam_pkg::*;
(
  input  logic [15:0]          i_pix,
  input  mode_e                i_mode,
  input  logic [3:0]           i_x,
  input  logic [3:0]           i_y,
  output logic [RGB444_W-1:0]  o_rgb
);

  logic w_unused_pix;
  assign w_unused_pix = ^{i_pix[11], i_pix[6:5], i_pix[0]};

  always_comb begin
    o_rgb = {i_pix[15:12], i_pix[10:7], i_pix[4:1]};
    case (i_mode)
      ModeYuvGrey: o_rgb = {3{i_pix[15:12]}};
      ModeTest:    o_rgb = {i_x, i_y, i_x ^ i_y};
      default:     ;
    endcase
  end

endmodule

// File: rtl/cam_capture_param.sv
// Camera byte-stream capture with decimation into a linear RGB444 frame buffer.
module cam_capture_param
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DECIM    = 2,
  parameter int unsigned ADDR_W   = 17
) (
  input logic          pclk,
  input logic          rst_n,
  cam_capture_param_if.slave cam
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 2);
  localparam int unsigned YW = $clog2(V_ACTIVE + 2);
  localparam int unsigned CW = $clog2(H_ACTIVE / DECIM + 1);
  localparam int unsigned RW = $clog2(V_ACTIVE / DECIM + 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_ACTIVE / DECIM);

  phase_e              r_phase, w_phase_d;
  mode_e               r_mode;
  logic                r_vsync, r_href, r_enable, r_cap;
  logic [7:0]          r_first;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [ADDR_W-1:0]   r_base, r_addr;
  logic [RGB444_W-1:0] r_dout, w_rgb;
  logic                r_we, r_frame_done, r_line_err;
  logic [15:0]         r_frame_cnt;

  logic w_vs_rise, w_vs_fall, w_href_fall, w_active, w_pix_valid, w_row_kept, w_keep;

  assign w_vs_rise   = cam.vsync & ~r_vsync;
  assign w_vs_fall   = ~cam.vsync & r_vsync;
  assign w_href_fall = r_href & ~cam.href;
  assign w_active    = ~cam.vsync & r_cap;
  assign w_pix_valid = w_active & cam.href & (r_phase == PhSecond);
  assign w_row_kept  = (r_y < YW'(V_ACTIVE)) && ((32'(r_y) % DECIM) == 32'd0);
  assign w_keep      = w_pix_valid && w_row_kept && (r_x < XW'(H_ACTIVE)) &&
                       ((32'(r_x) % DECIM) == 32'd0);

  cam_pix_convert u_conv (
    .i_pix  ({r_first, cam.d}),
    .i_mode (r_mode),
    .i_x    (4'(r_col)),
    .i_y    (4'(r_row)),
    .o_rgb  (w_rgb)
  );

  // Byte-pairing FSM: a line boundary or blanking always restarts at FIRST.
  always_comb begin
    w_phase_d = PhFirst;
    if (!cam.vsync && cam.href) begin
      w_phase_d = (r_phase == PhFirst) ? PhSecond : PhFirst;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_phase <= PhFirst;
    else        r_phase <= w_phase_d;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_enable     <= 1'b0;
      r_mode       <= ModeRgb565;
      r_cap        <= 1'b0;
      r_first      <= 8'h00;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 16'h0000;
      r_line_err   <= 1'b0;
    end else begin
      r_vsync      <= cam.vsync;
      r_href       <= cam.href;
      r_frame_done <= w_vs_rise & r_cap;
      if (cam.vsync) begin
        r_enable <= cam.enable;
        r_mode   <= mode_e'(cam.mode);
      end
      if (w_vs_fall)      r_cap <= r_enable;
      else if (w_vs_rise) r_cap <= 1'b0;
      if (w_vs_rise & r_cap) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (cam.href && r_phase == PhFirst) r_first <= cam.d;
      // Clear on vsync rise takes priority over a same-cycle set.
      if (w_vs_rise) r_line_err <= 1'b0;
      else if (w_href_fall && w_active && r_x != XW'(H_ACTIVE)) r_line_err <= 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_we   <= 1'b0;
    end else if (cam.vsync) begin
      r_x    <= '0;
      r_y    <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_base <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
    end else begin
      r_we <= w_keep;
      if (w_keep) begin
        r_addr <= r_base + ADDR_W'(r_col);
        r_dout <= w_rgb;
        r_col  <= r_col + 1'b1;
      end
      // x saturates one past the line width so over-long lines stay detectable.
      if (w_pix_valid && r_x <= XW'(H_ACTIVE)) r_x <= r_x + 1'b1;
      if (w_href_fall && w_active) begin
        r_x   <= '0;
        r_col <= '0;
        if (r_x != '0) begin
          if (r_y < YW'(V_ACTIVE)) r_y <= r_y + 1'b1;
          if (w_row_kept) begin
            r_base <= r_base + LineStep;
            r_row  <= r_row + 1'b1;
          end
        end
      end
    end
  end

  assign cam.addr       = r_addr;
  assign cam.dout       = r_dout;
  assign cam.we         = r_we;
  assign cam.frame_done = r_frame_done;
  assign cam.line_err   = r_line_err;
  assign cam.frame_cnt  = r_frame_cnt;

endmodule
